// File: rtl/rom_burst_pkg.sv
// Shared definitions for the ROM burst arbiter.
//   ADDR_W_DEFAULT : default ROM address width (32 words)
//   DATA_W_DEFAULT : default ROM data width
//   state_e        : burst FSM states
package rom_burst_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 5;
  localparam int unsigned DATA_W_DEFAULT = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rom_rr_arb.sv
// Two-way round-robin selector.
//   req    : per-requester request levels
//   last   : 1 when requester 1 was granted most recently, 0 for requester 0
//   winner : one-hot selected requester (all zero when nothing is requested)
module rom_rr_arb
  import rom_burst_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      // On a tie the requester that was not served last goes first.
      2'b11:   winner = last ? 2'b01 : 2'b10;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Arbitrates two burst readers onto a single synchronous ROM port.
//   clk, reset              : clock, asynchronous active-high reset
//   req                     : level requests, held until the matching grant bit is seen
//   start_addr0/1, len_m1_0/1 : burst start address and length-minus-one per requester
//   grant                   : one-cycle one-hot pulse when a burst is accepted
//   busy                    : high while a burst is being issued or drained
//   rom_addr / rom_q        : ROM address (registered) and ROM data (one cycle later)
//   rd_data, rd_valid, rd_last : returned data, owning requester, final-word flag
module rom_burst_arbiter
  import rom_burst_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] start_addr0,
  input  logic [ADDR_W-1:0] start_addr1,
  input  logic [ADDR_W-1:0] len_m1_0,
  input  logic [ADDR_W-1:0] len_m1_1,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_valid,
  output logic              rd_last
);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  // 1 when requester 1 holds the most recent grant.
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Words still to issue after the current one.
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        winner;

  rom_rr_arb u_arb (
    .req    (req),
    .last   (last_q),
    .winner (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      owner_q    <= 2'b00;
      rd_valid_q <= 2'b00;
      rd_last_q  <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = 2'b00;
    owner_d    = owner_q;
    rd_valid_d = 2'b00;
    rd_last_d  = 1'b0;
    last_d     = last_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ISSUE;
          grant_d = winner;
          owner_d = winner;
          last_d  = winner[1];
          addr_d  = winner[1] ? start_addr1 : start_addr0;
          cnt_d   = winner[1] ? len_m1_1 : len_m1_0;
        end
      end
      ISSUE: begin
        // The word addressed now comes back from the ROM next cycle, so
        // the valid/last flags are registered alongside it.
        rd_valid_d = owner_q;
        rd_last_d  = (cnt_q == '0);
        if (cnt_q == '0) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign rom_addr = addr_q;
  assign rd_data  = rom_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench for rom_burst_arbiter: directed bursts push expected words
// and grants into queues; a negedge monitor pops and compares.
module tb_rom_burst_arbiter;

  localparam int AW = 5;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [AW-1:0] sa0, sa1, l0, l1;
  logic [1:0]    grant;
  logic          busy;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_valid;
  logic          rd_last;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rom [32];

  typedef struct packed {
    logic [1:0]    owner;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] gq[$];

  rom_burst_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .start_addr0 (sa0),
    .start_addr1 (sa1),
    .len_m1_0    (l0),
    .len_m1_1    (l1),
    .grant       (grant),
    .busy        (busy),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model: data one cycle after the address.
  always @(posedge clk) rom_q <= rom[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic [1:0] owner, input logic [AW-1:0] sa, input int len);
    gq.push_back(owner);
    for (int k = 0; k <= len; k++) begin
      exp_t e;
      e.owner = owner;
      e.addr  = sa + AW'(k);
      e.data  = rom[e.addr];
      e.last  = (k == len);
      sb.push_back(e);
    end
  endtask

  // Monitor
  logic [AW-1:0] prev_addr = '0;
  exp_t          me;
  logic [1:0]    mg;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (grant != 2'b00) begin
        if (gq.size() == 0) check("unexpected_grant", 32'(grant), 32'd0);
        else begin
          mg = gq.pop_front();
          check("grant", 32'(grant), 32'(mg));
        end
      end
      if (rd_valid != 2'b00) begin
        if (sb.size() == 0) check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
        else begin
          me = sb.pop_front();
          check("rd_valid", 32'(rd_valid), 32'(me.owner));
          check("rd_data", 32'(rd_data), 32'(me.data));
          check("rd_last", 32'(rd_last), 32'(me.last));
          check("rom_addr", 32'(prev_addr), 32'(me.addr));
        end
      end
    end
    prev_addr = rom_addr;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  // One burst with requests dropped after grant; parameters are scrambled
  // during the burst to confirm they were latched.
  task automatic run_burst(input logic [1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] n0,
                           input logic [AW-1:0] a1, input logic [AW-1:0] n1,
                           input logic [1:0] w);
    int n;
    int bc;
    int len;
    len = w[1] ? int'(n1) : int'(n0);
    sa0 = a0; l0 = n0; sa1 = a1; l1 = n1;
    push_burst(w, w[1] ? a1 : a0, len);
    req = r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 2'b00 && n < 50);
    check("req_to_grant_cycles", 32'(n), 32'd1);
    req = 2'b00;
    sa0 = ~a0; sa1 = ~a1; l0 = ~n0; l1 = ~n1;
    req = r;  // still-held request during ISSUE must be ignored
    bc = 0;
    while (busy && bc < 100) begin
      bc++;
      @(negedge clk);
      if (bc == 1) begin
        req = 2'b00;
        check("grant_pulse_width", 32'(grant), 32'd0);
        check("first_rd_valid_latency", 32'(rd_valid), 32'(w));
      end
    end
    check("busy_cycles", 32'(bc), 32'(len + 2));
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    int gcnt;
    for (int i = 0; i < 32; i++) rom[i] = DW'(i * 97 + 11);
    reset = 1'b1;
    req = 2'b00;
    sa0 = '0; sa1 = '0; l0 = '0; l1 = '0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    #2 reset = 1'b0;

    // Single burst from requester 0: addresses 3..6.
    run_burst(2'b01, 5'd3, 5'd3, 5'd0, 5'd0, 2'b01);
    // Wrap from requester 1: 30,31,0,1.
    run_burst(2'b10, 5'd12, 5'd9, 5'd30, 5'd3, 2'b10);
    // Length one at 17.
    run_burst(2'b01, 5'd17, 5'd0, 5'd2, 5'd2, 2'b01);
    // Full length 0..31 from requester 1, busy 33 cycles.
    run_burst(2'b10, 5'd9, 5'd9, 5'd0, 5'd31, 2'b10);

    // Tie after reset with req held: 01, 10, 01.
    do_reset();
    sa0 = 5'd5; l0 = 5'd1; sa1 = 5'd20; l1 = 5'd2;
    push_burst(2'b01, 5'd5, 1);
    push_burst(2'b10, 5'd20, 2);
    push_burst(2'b01, 5'd5, 1);
    req = 2'b11;
    gcnt = 0;
    n = 0;
    while (gcnt < 3 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
      if (grant != 2'b00) begin
        gcnt++;
        // Preceding bursts must be fully delivered before each new grant.
        if (gcnt == 1) check("tie_sb_at_grant1", 32'(sb.size()), 32'd7);
        if (gcnt == 2) check("tie_sb_at_grant2", 32'(sb.size()), 32'd5);
        if (gcnt == 3) begin
          check("tie_sb_at_grant3", 32'(sb.size()), 32'd2);
          req = 2'b00;
        end
      end
    end
    req = 2'b00;
    check("tie_grant_count", 32'(gcnt), 32'd3);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("tie_sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the third ISSUE cycle of a len_m1=7 burst: only words 8, 9 arrive.
    sa0 = 5'd8; l0 = 5'd7;
    gq.push_back(2'b01);
    begin
      exp_t e;
      e = '{owner: 2'b01, addr: 5'd8, data: rom[8], last: 1'b0};
      sb.push_back(e);
      e = '{owner: 2'b01, addr: 5'd9, data: rom[9], last: 1'b0};
      sb.push_back(e);
    end
    req = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 2'b00 && n < 50);
    check("midrst_grant_seen", 32'(grant), 32'h1);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    #2 reset = 1'b0;
    check("midrst_sb_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("midrst_no_stray_grant", 32'(gq.size()), 32'd0);

    // Round-robin pointer reset: a tie goes to requester 0 again.
    run_burst(2'b11, 5'd25, 5'd2, 5'd4, 5'd1, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_burst_arbiter.md
ROM_BURST_ARBITER -- requirements
Module: rom_burst_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, ROM address width (32 words).
REQ-002 Parameter DATA_W, default 14, ROM data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester level request; bit i held high until grant[i] seen.
REQ-006 start_addr0 / start_addr1  input  ADDR_W  burst start address of requester 0 / 1.
REQ-007 len_m1_0 / len_m1_1  input  ADDR_W  burst length minus one (0..31 -> 1..32 words).
REQ-008 grant  output  2  one-hot, one-cycle pulse when a burst is accepted.
REQ-009 busy  output  1  high while not in IDLE.
REQ-010 rom_addr  output  ADDR_W  registered address to the ROM.
REQ-011 rom_q  input  DATA_W  ROM data, registered by the ROM one cycle after rom_addr.
REQ-012 rd_data  output  DATA_W  equals rom_q (combinational pass-through).
REQ-013 rd_valid  output  2  one-hot; bit i high when rd_data belongs to requester i.
REQ-014 rd_last  output  1  high with rd_valid on the final word of a burst.

Function
REQ-015 FSM states IDLE, ISSUE, DRAIN; reset state IDLE.
REQ-016 IDLE: if req != 0 at a rising edge, select winner, latch its start_addr/len_m1, pulse grant[winner] in the next cycle, go to ISSUE.
REQ-017 Arbitration round-robin: single request wins outright; on req=2'b11, the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-018 ISSUE: rom_addr presents the latched start address in the first ISSUE cycle, then increments by 1 per cycle, wrapping 31 -> 0 (modulo 2^ADDR_W).
REQ-019 ISSUE lasts exactly len_m1+1 cycles; after the cycle issuing the last address, go to DRAIN.
REQ-020 DRAIN lasts exactly one cycle, then IDLE; no new grant is issued in ISSUE or DRAIN.
REQ-021 rd_valid[i] is asserted exactly one cycle after each address issued for requester i (aligned with rom_q); rd_last likewise aligned with the last word.
REQ-022 Latency: req sampled at edge N -> grant and first rom_addr in cycle N+1 -> first rd_valid in cycle N+2; back-to-back bursts separated by at least one IDLE cycle.
REQ-023 req[i] still high on return to IDLE counts as a new request; req/param changes during ISSUE/DRAIN are ignored.
REQ-024 rom_addr holds its last value in IDLE and DRAIN.

Reset
REQ-025 reset asserted at any time, including mid-burst, forces within the same cycle: state IDLE, grant 0, rd_valid 0, rd_last 0, busy 0, rom_addr 0, round-robin pointer to "requester 1 last".
REQ-026 An interrupted burst is abandoned; no remaining words are delivered after reset release.

Structure
REQ-027 Package rom_burst_pkg holds ADDR_W/DATA_W defaults and the state enum (IDLE, ISSUE, DRAIN).
REQ-028 Round-robin selection lives in sub-module rom_rr_arb (req, last-grant pointer in; one-hot winner out); counters and FSM stay in the top.
REQ-029 The ROM itself is not instantiated; it connects via rom_addr/rom_q.

Verification
REQ-030 Single burst: req=01, start_addr0=3, len_m1_0=3 -> grant=01 one cycle, rom_addr 3,4,5,6, rd_valid=01 four cycles with data rom[3..6], rd_last on rom[6].
REQ-031 Wrap: start_addr1=30, len_m1_1=3 -> rom_addr 30,31,0,1; rd_data rom[30],rom[31],rom[0],rom[1].
REQ-032 Tie after reset: req=11 held -> grant 01 first, then 10, then 01; each burst finishes (rd_last) before next grant.
REQ-033 Full length: len_m1=31, start 0 -> 32 rd_valid cycles, addresses 0..31, busy high 33 cycles.
REQ-034 Reset mid-burst: assert reset in third ISSUE cycle of len_m1=7 burst -> rd_valid/grant/busy/rom_addr 0 immediately; no further rd_valid after release until a new grant.
REQ-035 Length one: len_m1=0, start 17 -> single rom_addr 17 cycle, one rd_valid with rd_last high.
